// File: rtl/netlenfilt.sv
// netlenfilt: packet-length policing for the abortable network stream.
// Forwards packets of MINWORDS..MAXWORDS words; runts and giants are aborted.
module netlenfilt #(
  parameter int DW       = 32,
  parameter int LGMAX    = 11,
  parameter int MINWORDS = 16,
  parameter int MAXWORDS = 380
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          S_AXIN_VALID,
  output logic          S_AXIN_READY,
  input  logic [DW-1:0] S_AXIN_DATA,
  input  logic          S_AXIN_LAST,
  input  logic          S_AXIN_ABORT,
  output logic          M_AXIN_VALID,
  input  logic          M_AXIN_READY,
  output logic [DW-1:0] M_AXIN_DATA,
  output logic          M_AXIN_LAST,
  output logic          M_AXIN_ABORT,
  output logic          o_runt,
  output logic          o_giant
);

  typedef enum logic {
    ST_PASS,
    ST_DROP
  } mode_e;

  localparam logic [LGMAX:0] MINW = (LGMAX+1)'(MINWORDS);
  localparam logic [LGMAX:0] MAXW = (LGMAX+1)'(MAXWORDS);
  localparam logic [LGMAX:0] ONE  = (LGMAX+1)'(1);

  mode_e            mode_q, mode_d;
  logic [LGMAX-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_abort_q, m_abort_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             runt_q, runt_d;
  logic             giant_q, giant_d;

  logic             accept;
  logic             in_pkt;
  logic [LGMAX:0]   n_w;
  logic             is_runt;
  logic             is_giant;

  assign S_AXIN_READY = (mode_q == ST_DROP)
                     || (!m_valid_q && !m_abort_q)
                     || M_AXIN_READY;

  assign accept   = S_AXIN_VALID && S_AXIN_READY;
  assign in_pkt   = (cnt_q != '0);
  assign n_w      = {1'b0, cnt_q} + ONE;
  assign is_runt  = S_AXIN_LAST && (n_w < MINW);
  assign is_giant = (n_w > MAXW);

  always_comb begin
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q && !M_AXIN_READY;
    m_abort_d = m_abort_q && !M_AXIN_READY;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    runt_d    = 1'b0;
    giant_d   = 1'b0;

    if (mode_q == ST_DROP) begin
      if (S_AXIN_ABORT || (accept && S_AXIN_LAST))
        mode_d = ST_PASS;
    end else if (S_AXIN_ABORT) begin
      // A pending beat belongs to the cancelled packet, so retract it
      if (in_pkt) begin
        m_valid_d = 1'b0;
        m_abort_d = 1'b1;
        cnt_d     = '0;
      end
    end else if (accept) begin
      unique case (1'b1)
        is_runt: begin
          m_abort_d = in_pkt;
          runt_d    = 1'b1;
          cnt_d     = '0;
        end
        is_giant: begin
          m_abort_d = 1'b1;
          giant_d   = 1'b1;
          cnt_d     = '0;
          if (!S_AXIN_LAST)
            mode_d = ST_DROP;
        end
        default: begin
          m_valid_d = 1'b1;
          m_data_d  = S_AXIN_DATA;
          m_last_d  = S_AXIN_LAST;
          cnt_d     = S_AXIN_LAST ? '0
                                  : n_w[LGMAX-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q    <= ST_PASS;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_abort_q <= 1'b0;
      runt_q    <= 1'b0;
      giant_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_abort_q <= m_abort_d;
      runt_q    <= runt_d;
      giant_q   <= giant_d;
    end
  end

  always_ff @(posedge i_clk) begin
    m_data_q <= m_data_d;
    m_last_q <= m_last_d;
  end

  assign M_AXIN_VALID = m_valid_q;
  assign M_AXIN_ABORT = m_abort_q;
  assign M_AXIN_DATA  = m_data_q;
  assign M_AXIN_LAST  = m_last_q;
  assign o_runt       = runt_q;
  assign o_giant      = giant_q;

endmodule

// File: tb/tb_netlenfilt.sv
// tb_netlenfilt: directed checks of netlenfilt with MINWORDS=4, MAXWORDS=8.
// Each scenario task drives stimulus and compares against hand-derived values.
module tb_netlenfilt;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        s_valid, s_ready, s_last, s_abort;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last, m_abort;
  logic [31:0] m_data;
  logic        o_runt, o_giant;

  logic        rdy;
  logic        bp_en;
  logic        bp_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] obq[$];
  int ab_cyc = 0, ab_cnt = 0;
  int runt_cnt = 0, giant_cnt = 0;
  int stall_viol = 0, both_viol = 0;
  logic        stall_p = 1'b0;
  logic [32:0] held = '0;

  always #5 clk = ~clk;

  assign m_ready = bp_en ? bp_q : rdy;

  always @(posedge clk) bp_q <= 1'($urandom_range(0, 1));

  netlenfilt #(
    .DW(32), .LGMAX(11), .MINWORDS(4), .MAXWORDS(8)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .S_AXIN_VALID(s_valid),
    .S_AXIN_READY(s_ready),
    .S_AXIN_DATA(s_data),
    .S_AXIN_LAST(s_last),
    .S_AXIN_ABORT(s_abort),
    .M_AXIN_VALID(m_valid),
    .M_AXIN_READY(m_ready),
    .M_AXIN_DATA(m_data),
    .M_AXIN_LAST(m_last),
    .M_AXIN_ABORT(m_abort),
    .o_runt(o_runt),
    .o_giant(o_giant)
  );

  always @(negedge clk) begin
    if (!i_reset) begin
      if (m_valid && m_ready) obq.push_back({m_last, m_data});
      if (m_abort) ab_cyc++;
      if (m_abort && m_ready) ab_cnt++;
      if (o_runt) runt_cnt++;
      if (o_giant) giant_cnt++;
      if (m_valid && m_abort) both_viol++;
      if (stall_p && m_valid && ({m_last, m_data} != held))
        stall_viol++;
      stall_p = m_valid && !m_ready;
      held    = {m_last, m_data};
    end else begin
      stall_p = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l,
                      output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!acc && waits <= 50) begin
      @(negedge clk);
      acc = s_ready;
      if (!acc) waits++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: data %0h not accepted after %0d cycles",
               d, waits);
    end
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base);
    int w;
    for (int i = 0; i < n; i++)
      beat(base + 32'(i), (i == n - 1), w);
  endtask

  task automatic test_reset;
    s_valid = 0; s_data = 0; s_last = 0; s_abort = 0;
    rdy = 1; bp_en = 0;
    i_reset = 1;
    idle(3);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b want 0", m_valid);
    end
    n_cmp++;
    if (m_abort !== 1'b0) begin
      n_err++; $display("FAIL rst_abort: got %b want 0", m_abort);
    end
    n_cmp++;
    if ({o_runt, o_giant} !== 2'b00) begin
      n_err++; $display("FAIL rst_pulses: got %b want 00", {o_runt, o_giant});
    end
    i_reset = 0;
    idle(1);
  endtask

  task automatic test_normal;
    int b, a0, r0, g0, w;
    b = obq.size(); a0 = ab_cyc; r0 = runt_cnt; g0 = giant_cnt;
    rdy = 1;
    beat(32'h10, 1'b0, w);
    n_cmp++;
    if ({m_valid, m_data} !== {1'b1, 32'h10}) begin
      n_err++; $display("FAIL norm_latency: got v=%b d=%0h want v=1 d=10",
                        m_valid, m_data);
    end
    for (int i = 1; i < 6; i++) beat(32'h10 + 32'(i), (i == 5), w);
    idle(3);
    n_cmp++;
    if (obq.size() - b !== 6) begin
      n_err++; $display("FAIL norm_count: got %0d want 6", obq.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (obq[b+i] !== {(i == 5), 32'h10 + 32'(i)}) begin
          n_err++; $display("FAIL norm_word%0d: got %0h want %0h", i,
                            obq[b+i], {(i == 5), 32'h10 + 32'(i)});
        end
      end
    end
    n_cmp++;
    if ({ab_cyc - a0, runt_cnt - r0, giant_cnt - g0} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL norm_side: got abort=%0d runt=%0d giant=%0d want 0 0 0",
                        ab_cyc - a0, runt_cnt - r0, giant_cnt - g0);
    end
  endtask

  task automatic test_runt;
    int b, a0, r0;
    b = obq.size(); a0 = ab_cyc; r0 = runt_cnt;
    send_pkt(3, 32'h20);
    idle(3);
    n_cmp++;
    if (obq.size() - b !== 2) begin
      n_err++; $display("FAIL runt_count: got %0d want 2", obq.size() - b);
    end else begin
      n_cmp++;
      if ({obq[b], obq[b+1]} !== {1'b0, 32'h20, 1'b0, 32'h21}) begin
        n_err++; $display("FAIL runt_words: got %0h %0h want 20 21",
                          obq[b], obq[b+1]);
      end
    end
    n_cmp++;
    if (ab_cyc - a0 !== 1) begin
      n_err++; $display("FAIL runt_abort: got %0d cycles want 1", ab_cyc - a0);
    end
    n_cmp++;
    if (runt_cnt - r0 !== 1) begin
      n_err++; $display("FAIL runt_pulse: got %0d want 1", runt_cnt - r0);
    end
    b = obq.size(); a0 = ab_cyc;
    send_pkt(4, 32'h30);
    idle(3);
    n_cmp++;
    if (obq.size() - b !== 4) begin
      n_err++; $display("FAIL min_count: got %0d want 4", obq.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obq[b+i] !== {(i == 3), 32'h30 + 32'(i)}) begin
          n_err++; $display("FAIL min_word%0d: got %0h want %0h", i,
                            obq[b+i], {(i == 3), 32'h30 + 32'(i)});
        end
      end
    end
    n_cmp++;
    if (ab_cyc - a0 !== 0) begin
      n_err++; $display("FAIL min_abort: got %0d want 0", ab_cyc - a0);
    end
  endtask

  task automatic test_single;
    int b, a0, r0;
    b = obq.size(); a0 = ab_cyc; r0 = runt_cnt;
    send_pkt(1, 32'hA5);
    idle(3);
    n_cmp++;
    if ({obq.size() - b, ab_cyc - a0} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL single_quiet: got words=%0d abort=%0d want 0 0",
                        obq.size() - b, ab_cyc - a0);
    end
    n_cmp++;
    if (runt_cnt - r0 !== 1) begin
      n_err++; $display("FAIL single_runt: got %0d want 1", runt_cnt - r0);
    end
  endtask

  task automatic test_giant;
    int b, a0, g0, w;
    b = obq.size(); a0 = ab_cnt; g0 = giant_cnt;
    rdy = 1;
    for (int i = 0; i < 9; i++) beat(32'h40 + 32'(i), 1'b0, w);
    rdy = 0;
    beat(32'h49, 1'b0, w);
    n_cmp++;
    if (w !== 0) begin
      n_err++; $display("FAIL drop_ready10: got %0d waits want 0", w);
    end
    beat(32'h4A, 1'b1, w);
    n_cmp++;
    if (w !== 0) begin
      n_err++; $display("FAIL drop_ready11: got %0d waits want 0", w);
    end
    idle(2);
    n_cmp++;
    if ({m_valid, m_abort} !== 2'b01) begin
      n_err++; $display("FAIL giant_hold: got v=%b a=%b want v=0 a=1",
                        m_valid, m_abort);
    end
    rdy = 1;
    idle(3);
    n_cmp++;
    if (obq.size() - b !== 8) begin
      n_err++; $display("FAIL giant_count: got %0d want 8", obq.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obq[b+i] !== {1'b0, 32'h40 + 32'(i)}) begin
          n_err++; $display("FAIL giant_word%0d: got %0h want %0h", i,
                            obq[b+i], {1'b0, 32'h40 + 32'(i)});
        end
      end
    end
    n_cmp++;
    if ({ab_cnt - a0, giant_cnt - g0} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL giant_side: got abort=%0d giant=%0d want 1 1",
                        ab_cnt - a0, giant_cnt - g0);
    end
    b = obq.size();
    send_pkt(5, 32'h70);
    idle(3);
    n_cmp++;
    if (obq.size() - b !== 5) begin
      n_err++; $display("FAIL giant_next: got %0d want 5", obq.size() - b);
    end else begin
      n_cmp++;
      if (obq[b+4] !== {1'b1, 32'h74}) begin
        n_err++; $display("FAIL giant_next_last: got %0h want 100000074",
                          obq[b+4]);
      end
    end
  endtask

  task automatic test_abort;
    int b, a0, w;
    b = obq.size(); a0 = ab_cnt;
    rdy = 1;
    for (int i = 0; i < 3; i++) beat(32'h50 + 32'(i), 1'b0, w);
    rdy = 0;
    s_abort = 1;
    idle(1);
    s_abort = 0;
    n_cmp++;
    if ({m_valid, m_abort} !== 2'b01) begin
      n_err++; $display("FAIL abort_rise: got v=%b a=%b want v=0 a=1",
                        m_valid, m_abort);
    end
    idle(3);
    n_cmp++;
    if (m_abort !== 1'b1) begin
      n_err++; $display("FAIL abort_hold: got %b want 1", m_abort);
    end
    rdy = 1;
    idle(1);
    n_cmp++;
    if (m_abort !== 1'b0) begin
      n_err++; $display("FAIL abort_clear: got %b want 0", m_abort);
    end
    idle(2);
    n_cmp++;
    if (obq.size() - b !== 2) begin
      n_err++; $display("FAIL abort_words: got %0d want 2", obq.size() - b);
    end else begin
      n_cmp++;
      if (obq[b+1] !== {1'b0, 32'h51}) begin
        n_err++; $display("FAIL abort_last_seen: got %0h want 51", obq[b+1]);
      end
    end
    n_cmp++;
    if (ab_cnt - a0 !== 1) begin
      n_err++; $display("FAIL abort_count: got %0d want 1", ab_cnt - a0);
    end
    n_cmp++;
    if (both_viol !== 0) begin
      n_err++; $display("FAIL abort_with_valid: got %0d cycles want 0",
                        both_viol);
    end
  endtask

  task automatic test_backpressure;
    int b, k;
    b = obq.size();
    bp_en = 1;
    send_pkt(5, 32'h60);
    k = 0;
    while (obq.size() - b < 5 && k < 100) begin
      idle(1);
      k++;
    end
    bp_en = 0;
    rdy = 1;
    idle(2);
    n_cmp++;
    if (obq.size() - b !== 5) begin
      n_err++; $display("FAIL bp_count: got %0d want 5", obq.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (obq[b+i] !== {(i == 4), 32'h60 + 32'(i)}) begin
          n_err++; $display("FAIL bp_word%0d: got %0h want %0h", i,
                            obq[b+i], {(i == 4), 32'h60 + 32'(i)});
        end
      end
    end
    n_cmp++;
    if (stall_viol !== 0) begin
      n_err++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol);
    end
  endtask

  task automatic test_mid_reset;
    int b, a0, r0, w;
    rdy = 1;
    beat(32'h80, 1'b0, w);
    beat(32'h81, 1'b0, w);
    i_reset = 1;
    idle(1);
    n_cmp++;
    if ({m_valid, m_abort, o_runt, o_giant} !== 4'b0000) begin
      n_err++; $display("FAIL mid_reset_out: got %b want 0000",
                        {m_valid, m_abort, o_runt, o_giant});
    end
    i_reset = 0;
    b = obq.size(); a0 = ab_cyc; r0 = runt_cnt;
    send_pkt(1, 32'h90);
    idle(3);
    n_cmp++;
    if ({obq.size() - b, ab_cyc - a0, runt_cnt - r0} !== {32'd0, 32'd0, 32'd1}) begin
      n_err++; $display("FAIL mid_reset_cnt: got words=%0d abort=%0d runt=%0d want 0 0 1",
                        obq.size() - b, ab_cyc - a0, runt_cnt - r0);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_runt;
    test_single;
    test_giant;
    test_abort;
    test_backpressure;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
